// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/retire wrapper around a combinational divider.
// Holds operands stable for SETTLE_CYCLES, then offers quotient and status.
module div_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  output logic [WIDTH-1:0] div_op1,
  output logic [WIDTH-1:0] div_op2,
  input  logic [WIDTH-1:0] div_result,
  input  logic [3:0]       div_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_status,
  output logic             busy
);

  localparam int ST_OVERFLOW = 0;
  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             dz, dz_n;
  logic [WIDTH-1:0] op1_n, op2_n;
  logic [WIDTH-1:0] res_n;
  logic [3:0]       st_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dz         <= 1'b0;
      div_op1    <= '0;
      div_op2    <= '0;
      out_result <= '0;
      out_status <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dz         <= dz_n;
      div_op1    <= op1_n;
      div_op2    <= op2_n;
      out_result <= res_n;
      out_status <= st_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dz_n    = dz;
    op1_n   = div_op1;
    op2_n   = div_op2;
    res_n   = out_result;
    st_n    = out_status;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          op1_n   = in_op1;
          op2_n   = in_op2;
          dz_n    = (in_op2 == '0);
          state_n = SETTLE;
          // zero divisor spends a single cycle here
          cnt_n   = (in_op2 == '0) ? '0
                  : CW'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          if (dz) begin
            res_n             = '1;
            st_n              = '0;
            st_n[ST_OVERFLOW] = 1'b1;
          end else begin
            res_n = div_result;
            st_n  = div_status;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench for div_issue_ctrl.
// Provides a behavioural divider and checks latency, results and flags.
module tb_div_issue_ctrl;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_op1;
  logic [W-1:0] in_op2;
  logic [W-1:0] div_op1;
  logic [W-1:0] div_op2;
  logic [W-1:0] div_result;
  logic [3:0]   div_status;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_status;
  logic         busy;

  int tests = 0;
  int fails = 0;

  div_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .div_op1    (div_op1),
    .div_op2    (div_op2),
    .div_result (div_result),
    .div_status (div_status),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_status (out_status),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (div_op2 != '0) div_result = div_op1 / div_op2;
    else div_result = 32'h1234_5678;
    div_status = {div_result[W-1], div_result == '0, 2'b11};
    if (div_op2 != '0) div_status[1:0] = 2'b00;
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] o,
                     input logic [W-1:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] r,
                                output logic [3:0] s);
    if (b == '0) begin
      r = '1;
      s = 4'b0001;
    end else begin
      r = a / b;
      s = {r[W-1], r == '0, 2'b00};
    end
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input string tag);
    logic [W-1:0] er;
    logic [3:0]   es;
    int           lat;
    model(a, b, er, es);
    send(a, b);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_op1_hold"}, div_op1, a);
      chk({tag, "_op2_hold"}, div_op2, b);
      step();
      lat++;
    end
    chk({tag, "_no_timeout"}, out_valid, 1'b1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, out_result, er);
    chk({tag, "_status"}, out_status, es);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_retired"}, out_valid, 1'b0);
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
    chk({tag, "_kept_result"}, out_result, er);
  endtask

  logic [W-1:0] ra, rb, er;
  logic [3:0]   es;
  int           got, acc, n;
  logic         seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_op1", div_op1, 32'd0);
    chk("rst_div_op2", div_op2, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_status", out_status, 4'd0);
    #10 rst_n = 1'b1;
    step();

    run_op(32'd100, 32'd7, S, "t1_100_7");
    run_op(32'd5, 32'd0, 1, "t2_div0");
    run_op(32'd3, 32'd9, S, "t3_zero");
    run_op(32'h8000_0000, 32'd1, S, "t3_neg");

    send(32'd50, 32'd5);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("t4_no_timeout", out_valid, 1'b1);
    in_valid = 1'b1;
    in_op1   = 32'd77;
    in_op2   = 32'd7;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_result", out_result, 32'd10);
      chk("t4_hold_in_ready", in_ready, 1'b0);
      chk("t4_hold_div_op1", div_op1, 32'd50);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_retire_valid", out_valid, 1'b0);
    chk("t4_retire_ready", in_ready, 1'b1);
    run_op(32'd77, 32'd7, S, "t4_next");

    send(32'd1000, 32'd3);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_in_ready", in_ready, 1'b1);
    chk("t5_rst_div_op1", div_op1, 32'd0);
    chk("t5_rst_result", out_result, 32'd0);
    #2 rst_n = 1'b1;
    step();
    run_op(32'd1000, 32'd3, S, "t5_after");

    acc       = 0;
    in_valid  = 1'b1;
    in_op1    = 32'd100;
    in_op2    = 32'd7;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (in_ready) acc++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("tput_accepts", acc, 4);
    chk("tput_idle", in_ready, 1'b1);

    got = 0;
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = (k == 3) ? 32'd0 : 32'($urandom_range(1, 5000));
      if (k == 5) rb = ra + 32'd1;
      model(ra, rb, er, es);
      send(ra, rb);
      seen = 1'b0;
      n    = 0;
      while (n < 60) begin
        if (out_valid && !seen) begin
          chk("t6_result", out_result, er);
          chk("t6_status", out_status, es);
          seen = 1'b1;
        end
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          step();
          got++;
          break;
        end
        step();
        n++;
      end
      out_ready = 1'b0;
      chk("t6_no_timeout", seen, 1'b1);
      chk("t6_retired", out_valid, 1'b0);
    end
    chk("t6_count", got, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
